// File: rtl/servo_pwm_driver.sv
// Three-axis hobby-servo PWM driver: fixed frame, per-axis pulse MIN_PULSE + pos*STEP_CYCLES,
// slew-limited position updates applied only at frame boundaries.
module servo_pwm_driver #(
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int MIN_PULSE     = 50_000,
  parameter int STEP_CYCLES   = 390,
  parameter int POS_WIDTH     = 7,
  parameter int SLEW_MAX      = 4,
  parameter int RESET_POS     = 64,
  parameter int CNT_WIDTH     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [POS_WIDTH-1:0] x,
  input  logic [POS_WIDTH-1:0] y,
  input  logic [POS_WIDTH-1:0] z,
  input  logic                 hold,
  output logic                 pwm_servo1,
  output logic                 pwm_servo2,
  output logic                 pwm_servo3,
  output logic                 frame_tick,
  output logic                 settled
);

  localparam int                     PW        = POS_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(PERIOD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   MIN_W     = CNT_WIDTH'(MIN_PULSE);
  localparam logic [CNT_WIDTH-1:0]   STEP_W    = CNT_WIDTH'(STEP_CYCLES);
  localparam logic [CNT_WIDTH-1:0]   WIDTH_RST = CNT_WIDTH'(MIN_PULSE + RESET_POS * STEP_CYCLES);
  localparam logic [POS_WIDTH-1:0]   POS_RST   = POS_WIDTH'(RESET_POS);
  localparam logic signed [PW-1:0]   SLEW      = PW'(SLEW_MAX);

  function automatic logic signed [PW-1:0] slew_clamp(input logic signed [PW-1:0] d);
    if (d > SLEW)       return SLEW;
    else if (d < -SLEW) return -SLEW;
    else                return d;
  endfunction

  // The clamped step always moves toward the target, so the result stays in range.
  function automatic logic [POS_WIDTH-1:0] slew_step(input logic [POS_WIDTH-1:0] pos,
                                                     input logic [POS_WIDTH-1:0] tgt);
    logic signed [PW-1:0] d;
    logic signed [PW-1:0] nxt;
    d   = signed'({1'b0, tgt}) - signed'({1'b0, pos});
    nxt = signed'({1'b0, pos}) + slew_clamp(d);
    return nxt[POS_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] pulse_width(input logic [POS_WIDTH-1:0] pos);
    return MIN_W + CNT_WIDTH'(pos) * STEP_W;
  endfunction

  logic [CNT_WIDTH-1:0] cnt;
  logic [POS_WIDTH-1:0] in_pos   [3];
  logic [POS_WIDTH-1:0] tgt_p0   [3];
  logic [POS_WIDTH-1:0] pos_p0   [3];
  logic [CNT_WIDTH-1:0] width_p1 [3];
  logic [2:0]           pwm_p2;
  logic                 all_eq;

  always_comb begin
    in_pos[0] = x;
    in_pos[1] = y;
    in_pos[2] = z;
    all_eq    = (pos_p0[0] == tgt_p0[0]) && (pos_p0[1] == tgt_p0[1]) &&
                (pos_p0[2] == tgt_p0[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CNT_WIDTH'(1);
      frame_tick <= (cnt == '0);
    end
  end

  // Stage p0: last cycle of the frame samples targets and takes one slew step.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        tgt_p0[i] <= POS_RST;
        pos_p0[i] <= POS_RST;
      end
    end else if (cnt == CNT_LAST && !hold) begin
      for (int i = 0; i < 3; i++) begin
        tgt_p0[i] <= in_pos[i];
        pos_p0[i] <= slew_step(pos_p0[i], in_pos[i]);
      end
    end
  end

  // Stage p1: widths and settled latch at cnt==0 so the whole frame compares one value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) width_p1[i] <= WIDTH_RST;
      settled <= 1'b0;
    end else if (cnt == '0) begin
      for (int i = 0; i < 3; i++) width_p1[i] <= pulse_width(pos_p0[i]);
      if (!hold) settled <= all_eq;
    end
  end

  // Stage p2: registered compare gives a glitch-free pulse starting one cycle after cnt==0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_p2 <= '0;
    end else begin
      for (int i = 0; i < 3; i++) pwm_p2[i] <= (cnt < width_p1[i]);
    end
  end

  assign pwm_servo1 = pwm_p2[0];
  assign pwm_servo2 = pwm_p2[1];
  assign pwm_servo3 = pwm_p2[2];

endmodule
